// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side req/ack signals of mem_port_arbiter.
// master is the arbiter's view; slave is the requesters-plus-memory environment.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;
    logic          busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               err, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (read-only) and data (read/write) requesters.
// Latency: req -> mem_req next cycle -> ack one cycle after mem_ack; one transaction in flight.
// Backpressure: losers wait with req held; ARB_TIMEOUT_EN adds a mem_ack timeout abort with err.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DATA_STREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int SW = $clog2(DATA_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          grant_i;
    logic          grant_d;
    logic          mem_done;
    logic          abort;
    logic          in_gnt;
    logic          data_first;
    logic          tmo_hit;
    logic          resp_d_q;
    logic [SW-1:0] streak_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

    // Data normally wins a tie; a saturated streak hands the next grant to fetch.
    assign data_first = bus.dm_req && (!bus.if_req || (streak_q != SW'(DATA_STREAK)));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else if (grant_i || grant_d) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else if (in_gnt) begin
            tmo_q <= tmo_q + 1'b1;
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = (state_q == RESP) && err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        mem_done = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_first) begin
                    grant_d = 1'b1;
                    state_d = GNT_D;
                end else if (bus.if_req) begin
                    grant_i = 1'b1;
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ack) begin
                    mem_done = 1'b1;
                    state_d  = RESP;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_d_q    <= 1'b0;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant_d) begin
                resp_d_q    <= 1'b1;
                mem_we_q    <= bus.dm_we;
                mem_addr_q  <= bus.dm_addr;
                mem_wdata_q <= bus.dm_wdata;
            end else if (grant_i) begin
                resp_d_q    <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
            end

            // Streak only counts data grants that made a waiting fetch wait longer.
            if (state_q == IDLE) begin
                if (grant_i || !bus.if_req) begin
                    streak_q <= '0;
                end else if (grant_d && (streak_q != SW'(DATA_STREAK))) begin
                    streak_q <= streak_q + 1'b1;
                end
            end

            if (mem_done) begin
                if (!resp_d_q) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!mem_we_q) begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end else if (abort) begin
                if (resp_d_q) begin
                    dm_rdata_q <= DW'(32'hDEAD_BEEF);
                end else begin
                    if_rdata_q <= DW'(32'hDEAD_BEEF);
                end
            end
        end
    end

    assign bus.mem_req   = in_gnt;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = (state_q == RESP) && !resp_d_q;
    assign bus.dm_ack    = (state_q == RESP) && resp_d_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
